// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry, idle line level and receiver FSM states.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE_DEF = 16;
  localparam int unsigned UART_DATA_BITS_DEF  = 8;
  localparam logic        UART_IDLE_LEVEL     = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } uart_rx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous input pins, with a configurable reset value.
module sync2 #(
  parameter int unsigned     WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop recovery with valid and frame-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS_DEF
) (
  input  logic                 clk_s,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 led_rx
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t       state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS:0]   shift_in;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;

  sync2 #(
    .WIDTH     (1),
    .RESET_VAL (UART_IDLE_LEVEL)
  ) u_sync_rx (
    .clk_i (clk_s),
    .rst_i (rst),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // New bit enters at the MSB so the first received bit ends up at the LSB.
  assign shift_in = {rx_s, shift_q};

  always_ff @(posedge clk_s or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    busy_d  = (state_q != RX_IDLE);

    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          tick_d  = '0;
        end
      end

      // Mid-start check rejects glitches shorter than half a bit.
      RX_START: begin
        if (tick_q == TICK_MID) begin
          if (rx_s) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            tick_d  = '0;
            bit_d   = '0;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      RX_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = shift_in[DATA_BITS:1];
          if (bit_q == BIT_LAST) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      RX_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_IDLE;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      // A held-low line (break) must not be decoded as repeated frames.
      RX_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = RX_IDLE;
        end
      end

      default: state_d = RX_IDLE;
    endcase
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;
  assign led_rx    = busy_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver, the counterpart of the existing `tx` transmitter. It recovers 8N1 frames (one start bit, 8 data bits LSB first, one stop bit, idle-high line) from the `rx` pin. It oversamples the line with `clk_s` and presents each received byte on a parallel port with a one-cycle valid strobe. It sits between the board RX pin and the processor's I/O register file.

## Interface
- `OVERSAMPLE`, default 16: `clk_s` cycles per bit period. Must be an even number ≥ 4.
- `DATA_BITS`, default 8: data bits per frame.
- `clk_s` input, 1: sample clock, running at `OVERSAMPLE` × baud.
- `rst` input, 1: reset, asynchronous and active-high.
- `rx` input, 1: serial line, asynchronous to `clk_s`, idle high.
- `data_out` output, `DATA_BITS`: last correctly framed byte; held until the next good frame.
- `valid` output, 1: one-cycle pulse when `data_out` updates.
- `frame_err` output, 1: one-cycle pulse when the stop bit is sampled low.
- `busy` output, 1: high whenever the FSM is not in IDLE.
- `led_rx` output, 1: board LED; mirrors `busy`.

## Operation
- `rx` passes through a 2-flop synchronizer, and the synchronizer reset value is 1. All FSM decisions use the synchronized signal `rx_s`.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. A tick counter of `$clog2(OVERSAMPLE)` bits and a bit index of `$clog2(DATA_BITS)` bits pace the frame.
- IDLE: when `rx_s` = 0, load tick = 0 and go to START.
- START: count to `OVERSAMPLE/2 - 1` (mid-bit).
  - If `rx_s` = 1 at that point, the event is a glitch: return to IDLE with no pulse.
  - Otherwise clear tick and go to DATA with bit index 0.
- DATA: sample `rx_s` every `OVERSAMPLE` cycles into the shift register, LSB first. After sample `DATA_BITS-1`, go to STOP.
- STOP: sample after `OVERSAMPLE` cycles.
  - `rx_s` = 1: copy the shift register to `data_out`, pulse `valid`, go to IDLE.
  - `rx_s` = 0: pulse `frame_err`, leave `data_out` unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s` = 1, then go to IDLE. This prevents a break condition from being read as a stream of frames.
- Reset values: `data_out` = 0, `valid` = 0, `frame_err` = 0, `busy` = 0, `led_rx` = 0, FSM = IDLE, synchronizer = 1.
- `rst` asserted mid-frame aborts immediately. No pulse is produced and the partial byte is discarded.

## Timing
- Let t0 be the first `clk_s` edge at which `rx_s` reads 0. This is 2–3 cycles after the pin falls.
- Mid-start sample at t0 + `OVERSAMPLE/2`.
- Data bit n sampled at t0 + `OVERSAMPLE/2` + (n+1)·`OVERSAMPLE`.
- Stop bit sampled at t0 + `OVERSAMPLE/2` + (`DATA_BITS`+1)·`OVERSAMPLE`. With defaults this is t0+152.
- `valid` or `frame_err` is registered on the edge that samples the stop bit. It is high for exactly one cycle, and `data_out` is stable in that same cycle.
- `busy` rises at t0+1 and falls one cycle after the stop sample.
- After a good frame the FSM is back in IDLE about half a bit before the stop bit ends. A following start bit is therefore detected with no gap cycles lost, so back-to-back frames must be received.
- `valid` and `frame_err` are never high in the same cycle.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_rx_state_t`.
  - constants `UART_OVERSAMPLE_DEF` = 16, `UART_DATA_BITS_DEF` = 8, `UART_IDLE_LEVEL` = 1'b1.
  - The `tx` block is to import the same constants.
- One sub-module, `sync2`: a parameterizable 2-flop synchronizer with a reset-value parameter, reused for other asynchronous pins.
- The top level contains the FSM, tick counter, bit index, shift register and output registers.

## Test plan
- Frame 0xAA (bits 0,1,0,1,0,1,0,1 LSB first, 16 cycles per bit): `data_out` = 0xAA, one `valid` pulse at t0+152, `frame_err` stays 0.
- Frame 0x11 immediately after 0xAA, no idle gap: two `valid` pulses 160 cycles apart, second `data_out` = 0x11.
- 4-cycle low glitch on an idle line: `busy` high for about 8 cycles, then low; no `valid`, no `frame_err`.
- Frame 0x55 with stop bit driven low, then the line held low for 50 cycles: one `frame_err` pulse, `data_out` keeps its previous value 0x11, `busy` stays high until the line returns high.
- `rst` pulsed during data bit 4 of 0xC3: all outputs return to 0 asynchronously. A following clean 0x3C frame is received correctly with a single `valid`.
- Sweep of all 256 byte values with `OVERSAMPLE` = 4: every byte is received intact, with no `frame_err`.
